ic_repl_ctrl: RTL and testbench
===============================

IC_REPL_CTRL -- requirements
Module: ic_repl_ctrl

Interface
REQ-001 Parameter B, default 64, SHALL set the cache block size in bytes.
REQ-002 Parameter BEAT_W, default 64, SHALL set the memory beat and rep_word width in bits.
REQ-003 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-004 Port clk_i  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port reset_i  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 Port ic_miss_i  in  1  SHALL carry the miss indication from the active cache set.
REQ-007 Port ic_addr_i  in  ADDR_W  SHALL carry the fetch address that missed.
REQ-008 Port flush_i  in  1  SHALL request abandonment of a pending fill (redirect).
REQ-009 Port mem_req_o  out  1  SHALL be the memory read request.
REQ-010 Port mem_addr_o  out  ADDR_W  SHALL be the block-aligned request address.
REQ-011 Port mem_gnt_i  in  1  SHALL indicate that memory accepted the request.
REQ-012 Port mem_rvalid_i  in  1  SHALL qualify mem_rdata_i.
REQ-013 Port mem_rdata_i  in  BEAT_W  SHALL carry one read beat.
REQ-014 Port ic_repl_grant_o  out  1  SHALL drive the cache set's replacement grant.
REQ-015 Port rep_word_o  out  BEAT_W  SHALL drive the replacement word into the cache set.
REQ-016 Port ic_stall_o  out  1  SHALL stall fetch while a fill is pending.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, RECV, STREAM, WAIT; NBEATS = B*8/BEAT_W (8 by default).
REQ-018 In IDLE, ic_miss_i=1 with flush_i=0 SHALL latch ic_addr_i with its low log2(B) bits cleared and enter REQ next cycle.
REQ-019 In REQ, mem_req_o=1 and mem_addr_o=latched address SHALL hold until mem_gnt_i=1; that edge enters RECV with beat count 0.
REQ-020 In RECV, each cycle with mem_rvalid_i=1 SHALL store mem_rdata_i in buffer slot beat_cnt and increment; idle gaps are allowed; the NBEATS-th beat enters STREAM.
REQ-021 In STREAM, ic_repl_grant_o SHALL be 1 for exactly NBEATS consecutive cycles with rep_word_o = slot 0,1,...,NBEATS-1 in order, then enter WAIT.
REQ-022 In WAIT, grant SHALL be 0 for one cycle (cache hit resolves), ic_miss_i SHALL be ignored, and the FSM returns to IDLE.
REQ-023 rep_word_o SHALL be 0 whenever ic_repl_grant_o=0.
REQ-024 ic_stall_o SHALL be 1 in REQ, RECV, STREAM, WAIT, and combinationally 1 in IDLE when ic_miss_i=1 and flush_i=0.
REQ-025 flush_i in REQ SHALL return to IDLE next cycle and drop mem_req_o, including when mem_gnt_i=1 the same cycle (flush wins, no RECV).
REQ-026 flush_i in RECV SHALL set a drop flag; remaining beats are still consumed, then IDLE is entered with no STREAM.
REQ-027 flush_i in STREAM or WAIT SHALL be ignored; the line completes.
REQ-028 mem_rvalid_i outside RECV SHALL be ignored; beat_cnt wraps only via state exit, never past NBEATS-1.
REQ-029 Minimum miss-to-grant latency SHALL be 1 + 1 + NBEATS cycles (gnt in first REQ cycle, back-to-back beats).

Reset
REQ-030 reset_i=0 SHALL asynchronously force IDLE, beat_cnt=0, drop flag=0, latched address=0, mem_req_o=0, mem_addr_o=0, ic_repl_grant_o=0, rep_word_o=0, ic_stall_o=0; buffer contents need not clear.
REQ-031 Reset asserted mid-RECV or mid-STREAM SHALL abort without further grant cycles; beats arriving after deassertion in IDLE are ignored.

Structure
REQ-032 Package ic_pkg SHALL hold the state enum ic_repl_state_t and constants IC_BLOCK_BYTES=64, IC_BEAT_W=64, IC_NBEATS=8.
REQ-033 The line buffer SHALL be a sub-module ic_line_buffer (NBEATS x BEAT_W, one write index, one read index, no reset on data).

Verification
REQ-034 Miss at 0x0000_1F44, gnt after 2 cycles, 8 back-to-back beats -> mem_addr_o=0x0000_1F40, 8 grant cycles replay beats in order, stall drops after WAIT.
REQ-035 Beats with 3 random single-cycle gaps -> STREAM starts only after beat 8; grant never gaps.
REQ-036 flush_i in REQ with mem_gnt_i=1 same cycle -> IDLE next cycle, no grant ever, later rvalid ignored.
REQ-037 flush_i after beat 3 of RECV -> beats 4-8 consumed, no grant, IDLE, stall=0 if ic_miss_i=0.
REQ-038 reset_i low during STREAM cycle 4 -> grant and rep_word_o 0 immediately; next miss fetches cleanly.

Source files
------------

// File: rtl/ic_pkg.sv
// ic_pkg: shared state encoding and default geometry for the I-cache refill path
package ic_pkg;
  typedef enum logic [2:0] {IDLE, REQ, RECV, STREAM, WAIT} ic_repl_state_t;
  localparam int IC_BLOCK_BYTES = 64;
  localparam int IC_BEAT_W = 64;
  localparam int IC_NBEATS = IC_BLOCK_BYTES * 8 / IC_BEAT_W;
endpackage

// File: rtl/ic_line_buffer.sv
// ic_line_buffer: one-line staging buffer between memory beats and cache replay
module ic_line_buffer #(
  parameter int NBEATS = 8,
  parameter int BEAT_W = 64,
  localparam int IW = $clog2(NBEATS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [BEAT_W-1:0] wdata,
  input  logic [IW-1:0]     raddr,
  output logic [BEAT_W-1:0] rdata
);
  logic [BEAT_W-1:0] mem [NBEATS];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ic_repl_ctrl.sv
// ic_repl_ctrl: fetches a missed block from memory and replays it beat by beat into the cache set
module ic_repl_ctrl
  import ic_pkg::*;
#(
  parameter int B = IC_BLOCK_BYTES,
  parameter int BEAT_W = IC_BEAT_W,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ic_miss_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [BEAT_W-1:0] mem_rdata_i,
  output logic              ic_repl_grant_o,
  output logic [BEAT_W-1:0] rep_word_o,
  output logic              ic_stall_o
);
  localparam int NBEATS = B * 8 / BEAT_W;
  localparam int IW = $clog2(NBEATS);
  localparam logic [IW-1:0] LAST = IW'(NBEATS - 1);
  ic_repl_state_t state;
  logic [IW-1:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [BEAT_W-1:0] rdata;
  logic drop;
  // cnt is the write slot during RECV and the read slot during STREAM
  ic_line_buffer #(.NBEATS(NBEATS), .BEAT_W(BEAT_W)) u_buf (
    .clk(clk_i),
    .we(state == RECV && mem_rvalid_i),
    .waddr(cnt),
    .wdata(mem_rdata_i),
    .raddr(cnt),
    .rdata(rdata)
  );
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state <= IDLE;
      cnt <= '0;
      drop <= 1'b0;
      addr_q <= '0;
      mem_req_o <= 1'b0;
      ic_repl_grant_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ic_miss_i && !flush_i) begin
          addr_q <= ic_addr_i & ~ADDR_W'(B - 1);
          mem_req_o <= 1'b1;
          state <= REQ;
        end
        REQ: if (flush_i || mem_gnt_i) begin
          mem_req_o <= 1'b0;
          cnt <= '0;
          state <= flush_i ? IDLE : RECV;
        end
        RECV: begin
          drop <= drop | flush_i;
          if (mem_rvalid_i) begin
            cnt <= cnt + IW'(1);
            // a flush seen on the final beat still abandons the line
            if (cnt == LAST) begin
              cnt <= '0;
              drop <= 1'b0;
              ic_repl_grant_o <= !(drop || flush_i);
              state <= (drop || flush_i) ? IDLE : STREAM;
            end
          end
        end
        STREAM: begin
          cnt <= cnt + IW'(1);
          if (cnt == LAST) begin
            cnt <= '0;
            ic_repl_grant_o <= 1'b0;
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  assign mem_addr_o = addr_q;
  assign rep_word_o = ic_repl_grant_o ? rdata : '0;
  assign ic_stall_o = reset_i && (state != IDLE || (ic_miss_i && !flush_i));
endmodule

// File: tb/tb_ic_repl_ctrl.sv
// tb_ic_repl_ctrl: directed table plus hand sequences for the refill controller
module tb_ic_repl_ctrl;
  logic clk = 1'b0, reset_i = 1'b0;
  logic ic_miss_i = 1'b0, flush_i = 1'b0, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] ic_addr_i = '0;
  logic [63:0] mem_rdata_i = '0;
  logic mem_req_o, ic_repl_grant_o, ic_stall_o;
  logic [31:0] mem_addr_o;
  logic [63:0] rep_word_o;
  int checks = 0, failures = 0;

  ic_repl_ctrl dut (
    .clk_i(clk), .reset_i(reset_i), .ic_miss_i(ic_miss_i), .ic_addr_i(ic_addr_i),
    .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .ic_repl_grant_o(ic_repl_grant_o), .rep_word_o(rep_word_o), .ic_stall_o(ic_stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic miss; logic [31:0] addr; logic flush, gnt, rvalid; logic [63:0] rdata;
    logic e_req; logic [31:0] e_addr; logic e_grant; logic [63:0] e_word; logic e_stall;
  } vec_t;
  vec_t tv [23];

  function automatic vec_t mk(logic m, logic [31:0] a, logic f, logic g, logic v, logic [63:0] d,
                              logic er, logic [31:0] ea, logic eg, logic [63:0] ew, logic es);
    vec_t r;
    r.miss = m; r.addr = a; r.flush = f; r.gnt = g; r.rvalid = v; r.rdata = d;
    r.e_req = er; r.e_addr = ea; r.e_grant = eg; r.e_word = ew; r.e_stall = es;
    return r;
  endfunction

  function automatic logic [63:0] dat(int s, int i);
    return {32'(s) ^ 32'hC0DE_0000, 32'(i) ^ 32'h00A5_5A00};
  endfunction

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic drive(logic m, logic [31:0] a, logic f, logic g, logic v, logic [63:0] d);
    @(posedge clk);
    #1;
    ic_miss_i = m; ic_addr_i = a; flush_i = f; mem_gnt_i = g; mem_rvalid_i = v; mem_rdata_i = d;
    @(negedge clk);
  endtask

  task automatic idle_chk(string n);
    chk({n, "_req"}, 64'(mem_req_o), 0);
    chk({n, "_grant"}, 64'(ic_repl_grant_o), 0);
    chk({n, "_word"}, rep_word_o, 0);
    chk({n, "_stall"}, 64'(ic_stall_o), 0);
  endtask

  task automatic full_fill(string n, logic [31:0] a, int s);
    drive(1, a, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk({n, "_addr"}, 64'(mem_addr_o), 64'(a & 32'hFFFF_FFC0));
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, dat(s, i));
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk({n, "_grant"}, 64'(ic_repl_grant_o), 1);
      chk({n, "_word"}, rep_word_o, dat(s, i));
    end
    drive(0, 0, 0, 0, 0, 0);
    chk({n, "_wait_grant"}, 64'(ic_repl_grant_o), 0);
    drive(0, 0, 0, 0, 0, 0);
    idle_chk({n, "_done"});
  endtask

  initial begin
    tv[0] = mk(1, 32'h0000_1F44, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tv[1] = mk(0, 0, 0, 0, 0, 0, 1, 32'h1F40, 0, 0, 1);
    tv[2] = tv[1];
    tv[3] = mk(0, 0, 0, 1, 0, 0, 1, 32'h1F40, 0, 0, 1);
    for (int i = 0; i < 8; i++) tv[4 + i] = mk(0, 0, 0, 0, 1, dat(1, i), 0, 32'h1F40, 0, 0, 1);
    for (int i = 0; i < 8; i++) tv[12 + i] = mk(0, 0, 0, 0, 0, 0, 0, 32'h1F40, 1, dat(1, i), 1);
    tv[20] = mk(1, 32'h5555_0000, 0, 0, 0, 0, 0, 32'h1F40, 0, 0, 1);
    tv[21] = mk(0, 0, 0, 0, 0, 0, 0, 32'h1F40, 0, 0, 0);
    tv[22] = tv[21];

    ic_miss_i = 1'b1;
    #12;
    chk("rst_req", 64'(mem_req_o), 0);
    chk("rst_addr", 64'(mem_addr_o), 0);
    chk("rst_grant", 64'(ic_repl_grant_o), 0);
    chk("rst_word", rep_word_o, 0);
    chk("rst_stall", 64'(ic_stall_o), 0);
    ic_miss_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;

    foreach (tv[k]) begin
      drive(tv[k].miss, tv[k].addr, tv[k].flush, tv[k].gnt, tv[k].rvalid, tv[k].rdata);
      chk($sformatf("tv%0d_req", k), 64'(mem_req_o), 64'(tv[k].e_req));
      chk($sformatf("tv%0d_addr", k), 64'(mem_addr_o), 64'(tv[k].e_addr));
      chk($sformatf("tv%0d_grant", k), 64'(ic_repl_grant_o), 64'(tv[k].e_grant));
      chk($sformatf("tv%0d_word", k), rep_word_o, tv[k].e_word);
      chk($sformatf("tv%0d_stall", k), 64'(ic_stall_o), 64'(tv[k].e_stall));
    end

    // beats with three single-cycle gaps; junk rvalid during replay must not disturb it
    begin
      int b = 0;
      drive(1, 32'h0000_2008, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 11; i++) begin
        logic v;
        v = !(i == 2 || i == 5 || i == 8);
        drive(0, 0, 0, 0, v, dat(2, b));
        chk("gap_recv_grant", 64'(ic_repl_grant_o), 0);
        chk("gap_recv_stall", 64'(ic_stall_o), 1);
        if (v) b++;
      end
      for (int i = 0; i < 8; i++) begin
        drive(0, 0, 0, 0, 1, 64'hDEAD_BEEF_0000_0000);
        chk("gap_grant", 64'(ic_repl_grant_o), 1);
        chk("gap_word", rep_word_o, dat(2, i));
      end
      drive(0, 0, 0, 0, 0, 0);
      chk("gap_wait_grant", 64'(ic_repl_grant_o), 0);
      drive(0, 0, 0, 0, 0, 0);
      idle_chk("gap_done");
    end

    // flush and grant collide in REQ: flush wins
    drive(1, 32'h0000_3000, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    chk("fgnt_req_held", 64'(mem_req_o), 1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 1, dat(3, i));
      idle_chk("fgnt_after");
    end

    // flush after beat 3: remaining five beats drained, no replay
    drive(1, 32'h0000_4040, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, dat(4, i));
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 3; i < 8; i++) begin
      drive(0, 0, 0, 0, 1, dat(4, i));
      chk("rflush_stall", 64'(ic_stall_o), 1);
      chk("rflush_grant", 64'(ic_repl_grant_o), 0);
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      idle_chk("rflush_after");
    end

    full_fill("clean1", 32'h0000_5088, 5);

    // async reset in the fourth replay cycle
    drive(1, 32'h0000_6000, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, dat(6, i));
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk("rstm_grant", 64'(ic_repl_grant_o), 1);
      chk("rstm_word", rep_word_o, dat(6, i));
    end
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    #1;
    idle_chk("rstm_now");
    chk("rstm_addr", 64'(mem_addr_o), 0);
    @(negedge clk);
    reset_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, dat(7, i));
      idle_chk("rstm_after");
    end
    full_fill("clean2", 32'h0000_7FFC, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
